chan_pkt_fifo: RTL and testbench

- Per-channel packet buffer between the USB/host write path and the channel FIFO reader.
- Stores fixed-size 128-word inband packets (header, timestamp, payload) in slots.
- Presents the oldest complete packet as show-ahead `fifodata`, advanced by `rdreq`; `skip` releases the rest of the current packet.
- Indicates packet availability via `pkt_waiting` and write-side space via `have_space`.

---
 rtl/chan_pkt_fifo.sv | 163 ++++++++++++++++
 tb/tb_chan_pkt_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_pkt_fifo.sv
// ---------------------------------------------------------------------------
// chan_pkt_fifo
// Per-channel packet buffer between the host write path and the channel FIFO
// reader. It stores fixed-size packets of 2^PKT_WORDS_LOG2 words in
// 2^NUM_PKTS_LOG2 slots. The oldest complete packet is presented show-ahead
// on fifodata.
//
// Ports
//   tx_clock     in   sole clock
//   reset_n      in   asynchronous active-low reset
//   flush        in   synchronous clear (only with CHAN_PKT_FIFO_FLUSH_EN)
//   wrreq        in   write wrdata this cycle
//   wrdata       in   packet word from the host path
//   have_space   out  at least one packet slot free (combinational)
//   overrun      out  sticky: a write was dropped
//   rdreq        in   ack current fifodata, advance one word
//   skip         in   release the current packet, move to the next slot
//   fifodata     out  show-ahead word at the read pointer (combinational)
//   pkt_waiting  out  a complete unreleased packet is available (comb.)
//   underflow    out  sticky: rdreq/skip issued with no packet stored
//   pkt_count    out  complete packets stored
//
// Optional feature macro: CHAN_PKT_FIFO_FLUSH_EN adds the flush input.
// ---------------------------------------------------------------------------
module chan_pkt_fifo #(
    parameter int unsigned PKT_WORDS_LOG2 = 7,
    parameter int unsigned NUM_PKTS_LOG2  = 2,
    parameter int unsigned DATA_W         = 32
) (
    input  logic                     tx_clock,
    input  logic                     reset_n,
`ifdef CHAN_PKT_FIFO_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic                     wrreq,
    input  logic [DATA_W-1:0]        wrdata,
    output logic                     have_space,
    output logic                     overrun,
    input  logic                     rdreq,
    input  logic                     skip,
    output logic [DATA_W-1:0]        fifodata,
    output logic                     pkt_waiting,
    output logic                     underflow,
    output logic [NUM_PKTS_LOG2:0]   pkt_count
);

    localparam int unsigned ADDR_W = NUM_PKTS_LOG2 + PKT_WORDS_LOG2;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = NUM_PKTS_LOG2 + 1;
    localparam int unsigned SLOTS  = 1 << NUM_PKTS_LOG2;

    logic [NUM_PKTS_LOG2-1:0]  r_wr_slot;
    logic [PKT_WORDS_LOG2-1:0] r_wr_off;
    logic [NUM_PKTS_LOG2-1:0]  r_rd_slot;
    logic [PKT_WORDS_LOG2-1:0] r_rd_off;
    logic [CNT_W-1:0]          r_pkt_count;
    logic                      r_overrun;
    logic                      r_underflow;
    logic [DATA_W-1:0]         r_mem [DEPTH];

    logic                      w_flush;
    logic                      w_have_space;
    logic                      w_has_pkt;
    logic                      w_wr_en;
    logic                      w_wr_last;
    logic                      w_wr_drop;
    logic                      w_rd_en;
    logic                      w_skip_en;
    logic                      w_rd_bad;
    logic [ADDR_W-1:0]         w_wr_addr;
    logic [ADDR_W-1:0]         w_rd_addr;
    logic [CNT_W-1:0]          w_pkt_count_nxt;

`ifdef CHAN_PKT_FIFO_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Space and availability come from registered state only, so a skip in
    // the same cycle cannot rescue a write to a full buffer.
    assign w_have_space = (r_pkt_count < CNT_W'(SLOTS));
    assign w_has_pkt    = (r_pkt_count != '0);

    assign w_wr_en   = wrreq & w_have_space & ~w_flush;
    assign w_wr_drop = wrreq & ~w_have_space & ~w_flush;
    assign w_wr_last = w_wr_en & (r_wr_off == '1);
    assign w_skip_en = skip & w_has_pkt & ~w_flush;
    assign w_rd_en   = rdreq & ~skip & w_has_pkt & ~w_flush;
    assign w_rd_bad  = (rdreq | skip) & ~w_has_pkt & ~w_flush;

    assign w_wr_addr = {r_wr_slot, r_wr_off};
    assign w_rd_addr = {r_rd_slot, r_rd_off};

    // Packet completion and release in the same cycle cancel out.
    always_comb begin
        w_pkt_count_nxt = r_pkt_count;
        if (w_wr_last && !w_skip_en) begin
            w_pkt_count_nxt = r_pkt_count + CNT_W'(1);
        end else if (!w_wr_last && w_skip_en) begin
            w_pkt_count_nxt = r_pkt_count - CNT_W'(1);
        end
    end

    // Pointer, count and sticky flag state.
    always_ff @(posedge tx_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_slot   <= '0;
            r_wr_off    <= '0;
            r_rd_slot   <= '0;
            r_rd_off    <= '0;
            r_pkt_count <= '0;
            r_overrun   <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_flush) begin
            r_wr_slot   <= '0;
            r_wr_off    <= '0;
            r_rd_slot   <= '0;
            r_rd_off    <= '0;
            r_pkt_count <= '0;
            r_overrun   <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_off <= r_wr_off + PKT_WORDS_LOG2'(1);
                if (w_wr_last) begin
                    r_wr_slot <= r_wr_slot + NUM_PKTS_LOG2'(1);
                end
            end
            if (w_skip_en) begin
                r_rd_slot <= r_rd_slot + NUM_PKTS_LOG2'(1);
                r_rd_off  <= '0;
            end else if (w_rd_en) begin
                // Offset wraps inside the slot; only skip changes slot.
                r_rd_off <= r_rd_off + PKT_WORDS_LOG2'(1);
            end
            r_pkt_count <= w_pkt_count_nxt;
            if (w_wr_drop) begin
                r_overrun <= 1'b1;
            end
            if (w_rd_bad) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Packet RAM, contents intentionally not reset.
    always_ff @(posedge tx_clock) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= wrdata;
        end
    end

    assign fifodata    = r_mem[w_rd_addr];
    assign have_space  = w_have_space;
    // Equivalent to (count - skip) != 0 for a stored packet; written as a
    // compare so the empty case does not wrap to a false "waiting".
    assign pkt_waiting = (r_pkt_count > CNT_W'(skip));
    assign overrun     = r_overrun;
    assign underflow   = r_underflow;
    assign pkt_count   = r_pkt_count;

endmodule

// File: tb/tb_chan_pkt_fifo.sv
module tb_chan_pkt_fifo;

    logic        tx_clock = 1'b0;
    logic        reset_n;
    logic        wrreq;
    logic [31:0] wrdata;
    logic        have_space;
    logic        overrun;
    logic        rdreq;
    logic        skip;
    logic [31:0] fifodata;
    logic        pkt_waiting;
    logic        underflow;
    logic [2:0]  pkt_count;
`ifdef CHAN_PKT_FIFO_FLUSH_EN
    logic        flush;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    chan_pkt_fifo dut (
        .tx_clock    (tx_clock),
        .reset_n     (reset_n),
`ifdef CHAN_PKT_FIFO_FLUSH_EN
        .flush       (flush),
`endif
        .wrreq       (wrreq),
        .wrdata      (wrdata),
        .have_space  (have_space),
        .overrun     (overrun),
        .rdreq       (rdreq),
        .skip        (skip),
        .fifodata    (fifodata),
        .pkt_waiting (pkt_waiting),
        .underflow   (underflow),
        .pkt_count   (pkt_count)
    );

    always #5 tx_clock = ~tx_clock;

    typedef struct {
        logic        rdreq;
        logic        skip;
        logic        chk_wait;
        logic        exp_wait;
        logic [2:0]  exp_cnt;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_uflow;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock edge; returns 1 time unit after it.
    task automatic step();
        @(posedge tx_clock);
        #1;
    endtask

    task automatic wr_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wrreq  = 1'b1;
            wrdata = base + 32'(i);
            step();
        end
        wrreq = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse(input logic do_chk);
        #2 reset_n = 1'b0;
        #1;
        if (do_chk) begin
            chk("async_rst_cnt",   32'(pkt_count),   32'd0);
            chk("async_rst_space", 32'(have_space),  32'd1);
            chk("async_rst_wait",  32'(pkt_waiting), 32'd0);
            chk("async_rst_ovr",   32'(overrun),     32'd0);
            chk("async_rst_udf",   32'(underflow),   32'd0);
        end
        #2 reset_n = 1'b1;
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 32'h1, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 32'h2, 1'b0};
        vt[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 32'h3, 1'b0};
        vt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0};
        vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 1'b1};
        vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 1'b1};

        reset_n = 1'b0;
        wrreq   = 1'b0;
        wrdata  = '0;
        rdreq   = 1'b0;
        skip    = 1'b0;
`ifdef CHAN_PKT_FIFO_FLUSH_EN
        flush   = 1'b0;
`endif
        #3;
        chk("rst_cnt",   32'(pkt_count),   32'd0);
        chk("rst_space", 32'(have_space),  32'd1);
        chk("rst_wait",  32'(pkt_waiting), 32'd0);
        chk("rst_ovr",   32'(overrun),     32'd0);
        chk("rst_udf",   32'(underflow),   32'd0);
        #9 reset_n = 1'b1;
        step();

        // One full packet; count rises only with word 127.
        wr_words(32'h0, 127);
        chk("p0_cnt_w126", 32'(pkt_count), 32'd0);
        wr_words(32'h7F, 1);
        chk("p0_cnt",  32'(pkt_count),   32'd1);
        chk("p0_wait", 32'(pkt_waiting), 32'd1);
        chk("p0_w0",   fifodata,         32'h0);

        // Reads, mid-packet skip, underflow.
        for (int i = 0; i < 6; i++) begin
            rdreq = vt[i].rdreq;
            skip  = vt[i].skip;
            #1;
            if (vt[i].chk_wait) chk($sformatf("vec%0d_wait", i), 32'(pkt_waiting), 32'(vt[i].exp_wait));
            step();
            rdreq = 1'b0;
            skip  = 1'b0;
            chk($sformatf("vec%0d_cnt", i), 32'(pkt_count), 32'(vt[i].exp_cnt));
            chk($sformatf("vec%0d_udf", i), 32'(underflow), 32'(vt[i].exp_uflow));
            if (vt[i].chk_data) chk($sformatf("vec%0d_data", i), fifodata, vt[i].exp_data);
        end

        // Underflow left pointers alone: next packet lands in slot 1 and is read there.
        wr_words(32'h100, 128);
        chk("p1_cnt", 32'(pkt_count), 32'd1);
        chk("p1_w0",  fifodata,       32'h100);
        rdreq = 1'b1;
        for (int i = 0; i < 127; i++) step();
        rdreq = 1'b0;
        chk("p1_w127", fifodata, 32'h17F);
        rdreq = 1'b1;
        step();
        rdreq = 1'b0;
        chk("p1_wrap_w0",  fifodata,       32'h100);
        chk("p1_wrap_cnt", 32'(pkt_count), 32'd1);

        // Reset in the middle of a write.
        wr_words(32'h200, 50);
        reset_pulse(1'b1);
        step();

        // Fill all four slots.
        for (int p = 0; p < 3; p++) wr_words(32'hA000_0000 + 32'(p * 256), 128);
        wr_words(32'hA000_0300, 127);
        chk("fill_cnt_511",   32'(pkt_count),  32'd3);
        chk("fill_space_511", 32'(have_space), 32'd1);
        wr_words(32'hA000_037F, 1);
        chk("fill_cnt",   32'(pkt_count),  32'd4);
        chk("fill_space", 32'(have_space), 32'd0);
        chk("fill_ovr0",  32'(overrun),    32'd0);
        wr_words(32'hDEAD_0000, 1);
        chk("ovr_set", 32'(overrun),   32'd1);
        chk("ovr_cnt", 32'(pkt_count), 32'd4);
        chk("ovr_s0w0", fifodata,      32'hA000_0000);
        rdreq = 1'b1;
        step();
        rdreq = 1'b0;
        chk("ovr_s0w1", fifodata, 32'hA000_0001);

        // Dropped write with skip in the same cycle: still dropped.
        wrreq  = 1'b1;
        skip   = 1'b1;
        wrdata = 32'hBEEF_0000;
        step();
        wrreq = 1'b0;
        skip  = 1'b0;
        chk("drop_skip_cnt",   32'(pkt_count),  32'd3);
        chk("drop_skip_space", 32'(have_space), 32'd1);
        chk("drop_skip_data",  fifodata,        32'hA000_0100);
        wr_words(32'hA000_0400, 127);
        chk("s0_reuse_cnt127", 32'(pkt_count), 32'd3);
        wr_words(32'hA000_047F, 1);
        chk("s0_reuse_cnt128", 32'(pkt_count), 32'd4);
        for (int p = 2; p <= 4; p++) begin
            skip = 1'b1;
            step();
            skip = 1'b0;
            chk($sformatf("skip_to_p%0d", p), fifodata, 32'hA000_0000 + 32'(p * 256));
        end
        chk("skip_end_cnt", 32'(pkt_count), 32'd1);

        // Packet completion coinciding with skip.
        reset_pulse(1'b0);
        step();
        wr_words(32'hB000_0000, 128);
        wr_words(32'hB000_0100, 128);
        wr_words(32'hB000_0200, 127);
        wrreq  = 1'b1;
        wrdata = 32'hB000_027F;
        skip   = 1'b1;
        #1;
        chk("sim_wait", 32'(pkt_waiting), 32'd1);
        step();
        wrreq = 1'b0;
        skip  = 1'b0;
        chk("sim_cnt",  32'(pkt_count), 32'd2);
        chk("sim_data", fifodata,        32'hB000_0100);
        skip = 1'b1;
        step();
        skip = 1'b0;
        chk("sim_next_cnt",  32'(pkt_count), 32'd1);
        chk("sim_next_data", fifodata,        32'hB000_0200);

`ifdef CHAN_PKT_FIFO_FLUSH_EN
        reset_pulse(1'b0);
        step();
        for (int p = 0; p < 3; p++) wr_words(32'hC000_0000 + 32'(p * 256), 128);
        wr_words(32'hC000_0300, 50);
        flush  = 1'b1;
        wrreq  = 1'b1;
        wrdata = 32'hEEEE_0000;
        step();
        flush = 1'b0;
        wrreq = 1'b0;
        chk("flush_cnt",   32'(pkt_count),   32'd0);
        chk("flush_space", 32'(have_space),  32'd1);
        chk("flush_wait",  32'(pkt_waiting), 32'd0);
        wr_words(32'hD000_0000, 127);
        chk("flush_cnt127", 32'(pkt_count), 32'd0);
        wr_words(32'hD000_007F, 1);
        chk("flush_cnt128", 32'(pkt_count), 32'd1);
        chk("flush_w0",     fifodata,        32'hD000_0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
